// File: rtl/sipo_collector_pkg.sv
// Shared types for the serial-in/parallel-out collector: FSM state and counter sizing.
package sipo_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // Bits needed to count 0..frame_len inclusive.
  function automatic int cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/sipo_collector_if.sv
// Serial input / parallel output bundle for sipo_collector.
// SIPO_COLLECTOR_PARITY_EN adds parity_err.
interface sipo_collector_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic             busy;
  logic             overrun;
`ifdef SIPO_COLLECTOR_PARITY_EN
  logic             parity_err;

  modport master (input sin, sin_valid, pout_ready,
                  output pout, pout_valid, busy, overrun, parity_err);
  modport slave  (output sin, sin_valid, pout_ready,
                  input pout, pout_valid, busy, overrun, parity_err);
`else
  modport master (input sin, sin_valid, pout_ready,
                  output pout, pout_valid, busy, overrun);
  modport slave  (output sin, sin_valid, pout_ready,
                  input pout, pout_valid, busy, overrun);
`endif
endinterface

// File: rtl/sipo_collector_frame_counter.sv
// Bit counter for one serial frame; o_tc flags that the next accepted bit completes the frame.
module sipo_frame_counter #(
  parameter int TERM = 4,
  parameter int CW   = sipo_pkg::cnt_width(TERM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_clear,
  output logic [CW-1:0] o_cnt,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;

  // Clear wins over inc so the completing bit leaves the counter at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_inc)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CW'(TERM - 1));
endmodule

// File: rtl/sipo_collector.sv
// Serial-to-parallel collector with a one-word output register and backpressure.
// Define SIPO_COLLECTOR_PARITY_EN for WIDTH data bits plus one even-parity bit per frame.
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst,
  sipo_collector_if.master bus
);
`ifdef SIPO_COLLECTOR_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = cnt_width(FRAME);

  state_e           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_overrun;
  logic [CW-1:0]    w_cnt;
  logic             w_tc;
  logic             w_accept;
  logic             w_free;
  logic             w_clear;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_word;
  logic             w_shift_en;

  assign w_accept = bus.sin_valid && (r_state == COLLECT);
  assign w_free   = !r_pout_valid || bus.pout_ready;
  assign w_clear  = (w_accept && w_tc && w_free) || ((r_state == FULL) && bus.pout_ready);

  if (MSB_FIRST) begin : g_msb
    assign w_shift = {r_sh[WIDTH-2:0], bus.sin};
  end else begin : g_lsb
    assign w_shift = {bus.sin, r_sh[WIDTH-1:1]};
  end

`ifdef SIPO_COLLECTOR_PARITY_EN
  logic r_par;
  logic r_perr;
  // The final frame bit is parity: it never enters the shift stage.
  assign w_shift_en = (w_cnt < CW'(WIDTH));
  assign w_word     = r_sh;
  assign bus.parity_err = r_perr;
`else
  assign w_shift_en = 1'b1;
  assign w_word     = w_shift;
`endif

  sipo_frame_counter #(.TERM(FRAME), .CW(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_accept),
    .i_clear(w_clear),
    .o_cnt  (w_cnt),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= COLLECT;
      r_sh         <= '0;
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SIPO_COLLECTOR_PARITY_EN
      r_par        <= 1'b0;
      r_perr       <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (bus.pout_ready) r_pout_valid <= 1'b0;
          if (w_accept) begin
            if (w_shift_en) r_sh <= w_shift;
`ifdef SIPO_COLLECTOR_PARITY_EN
            r_par <= r_par ^ bus.sin;
`endif
            if (w_tc) begin
              if (w_free) begin
                r_pout       <= w_word;
                r_pout_valid <= 1'b1;
`ifdef SIPO_COLLECTOR_PARITY_EN
                r_perr <= r_par ^ bus.sin;
                r_par  <= 1'b0;
`endif
              end else begin
                r_state <= FULL;
              end
            end
          end
        end
        FULL: begin
          // Word parked in the shift stage; incoming bits are dropped and flagged.
          r_overrun <= bus.sin_valid;
          if (bus.pout_ready) begin
            r_pout       <= r_sh;
            r_pout_valid <= 1'b1;
            r_state      <= COLLECT;
`ifdef SIPO_COLLECTOR_PARITY_EN
            r_perr <= r_par;
            r_par  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign bus.pout       = r_pout;
  assign bus.pout_valid = r_pout_valid;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = (w_cnt != '0) || (r_state == FULL);
endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sin_valid = 1'b0;
  logic pout_ready = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sipo_collector_if #(.WIDTH(4)) if_m ();
  sipo_collector_if #(.WIDTH(4)) if_l ();

  assign if_m.sin = sin;
  assign if_m.sin_valid = sin_valid;
  assign if_m.pout_ready = pout_ready;
  assign if_l.sin = sin;
  assign if_l.sin_valid = sin_valid;
  assign if_l.pout_ready = pout_ready;

  sipo_collector #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if_m));
  sipo_collector #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if_l));

  typedef struct {
    logic       v, s, r;
    logic [3:0] em, el;
    logic       ev, eb, eo;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, s, r, input logic [3:0] em, el, input logic ev, eb, eo);
    vec_t t;
    t.v = v; t.s = s; t.r = r; t.em = em; t.el = el; t.ev = ev; t.eb = eb; t.eo = eo;
    tbl.push_back(t);
  endtask

  // Drive on the falling edge, sample 1 time unit after the following rising edge.
  task automatic step(input logic v, s, r);
    @(negedge clk);
    sin_valid = v; sin = s; pout_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " pout_m"}, 32'(if_m.pout), 32'h0);
    check({tag, " pout_l"}, 32'(if_l.pout), 32'h0);
    check({tag, " vld"}, 32'({if_m.pout_valid, if_l.pout_valid}), 32'h0);
    check({tag, " busy"}, 32'({if_m.busy, if_l.busy}), 32'h0);
    check({tag, " ovr"}, 32'({if_m.overrun, if_l.overrun}), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

`ifndef SIPO_COLLECTOR_PARITY_EN
    // Continuous words, ready held high, one idle gap inside word 3.
    add(1,1,1, 4'b0000,4'b0000, 0,1,0);
    add(1,0,1, 4'b0000,4'b0000, 0,1,0);
    add(1,1,1, 4'b0000,4'b0000, 0,1,0);
    add(1,1,1, 4'b1011,4'b1101, 1,0,0);
    add(1,0,1, 4'b1011,4'b1101, 0,1,0);
    add(1,1,1, 4'b1011,4'b1101, 0,1,0);
    add(1,1,1, 4'b1011,4'b1101, 0,1,0);
    add(1,0,1, 4'b0110,4'b0110, 1,0,0);
    add(1,1,1, 4'b0110,4'b0110, 0,1,0);
    add(0,0,1, 4'b0110,4'b0110, 0,1,0);
    add(1,1,1, 4'b0110,4'b0110, 0,1,0);
    add(1,0,1, 4'b0110,4'b0110, 0,1,0);
    add(1,0,1, 4'b1100,4'b0011, 1,0,0);
    add(0,0,1, 4'b1100,4'b0011, 0,0,0);
    // Backpressure: second word parks in FULL, extra bit overruns.
    add(1,1,0, 4'b1100,4'b0011, 0,1,0);
    add(1,0,0, 4'b1100,4'b0011, 0,1,0);
    add(1,1,0, 4'b1100,4'b0011, 0,1,0);
    add(1,0,0, 4'b1010,4'b0101, 1,0,0);
    add(1,0,0, 4'b1010,4'b0101, 1,1,0);
    add(1,1,0, 4'b1010,4'b0101, 1,1,0);
    add(1,1,0, 4'b1010,4'b0101, 1,1,0);
    add(1,0,0, 4'b1010,4'b0101, 1,1,0);
    add(1,1,0, 4'b1010,4'b0101, 1,1,1);
    add(0,0,0, 4'b1010,4'b0101, 1,1,0);
    add(0,0,1, 4'b0110,4'b0110, 1,0,0);
    add(1,1,1, 4'b0110,4'b0110, 0,1,0);
    add(1,1,1, 4'b0110,4'b0110, 0,1,0);
    add(1,1,1, 4'b0110,4'b0110, 0,1,0);
    add(1,0,1, 4'b1110,4'b0111, 1,0,0);
    // Last bit lands on the same edge as the handshake of the previous word.
    add(1,0,0, 4'b1110,4'b0111, 1,1,0);
    add(1,0,0, 4'b1110,4'b0111, 1,1,0);
    add(1,1,0, 4'b1110,4'b0111, 1,1,0);
    add(1,1,1, 4'b0011,4'b1100, 1,0,0);
    add(0,0,1, 4'b0011,4'b1100, 0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].r);
      check($sformatf("row%0d pout_m", i), 32'(if_m.pout), 32'(tbl[i].em));
      check($sformatf("row%0d pout_l", i), 32'(if_l.pout), 32'(tbl[i].el));
      check($sformatf("row%0d vld", i), 32'({if_m.pout_valid, if_l.pout_valid}), 32'({tbl[i].ev, tbl[i].ev}));
      check($sformatf("row%0d busy", i), 32'({if_m.busy, if_l.busy}), 32'({tbl[i].eb, tbl[i].eb}));
      check($sformatf("row%0d ovr", i), 32'({if_m.overrun, if_l.overrun}), 32'({tbl[i].eo, tbl[i].eo}));
    end
`else
    // Even parity: 1011 with parity 1 is clean, with parity 0 is an error.
    step(1,1,1); step(1,0,1); step(1,1,1); step(1,1,1);
    check("par busy", 32'(if_m.busy), 32'h1);
    step(1,1,1);
    check("par0 pout_m", 32'(if_m.pout), 32'hB);
    check("par0 pout_l", 32'(if_l.pout), 32'hD);
    check("par0 vld", 32'(if_m.pout_valid), 32'h1);
    check("par0 err", 32'({if_m.parity_err, if_l.parity_err}), 32'h0);
    step(1,1,1); step(1,0,1); step(1,1,1); step(1,1,1);
    step(1,0,1);
    check("par1 pout_m", 32'(if_m.pout), 32'hB);
    check("par1 vld", 32'(if_m.pout_valid), 32'h1);
    check("par1 err", 32'({if_m.parity_err, if_l.parity_err}), 32'h3);
    step(0,0,1);
`endif

    // Asynchronous reset mid-word, away from any clock edge.
    step(1,1,0);
    step(1,1,0);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
`ifdef SIPO_COLLECTOR_PARITY_EN
    check("async_rst perr", 32'(if_m.parity_err), 32'h0);
`endif
    sin_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1,0,1);
    check("post_rst busy", 32'(if_m.busy), 32'h1);
    step(1,1,1); step(1,0,1); step(1,1,1);
`ifdef SIPO_COLLECTOR_PARITY_EN
    step(1,0,1);
`endif
    check("post_rst pout_m", 32'(if_m.pout), 32'h5);
    check("post_rst pout_l", 32'(if_l.pout), 32'hA);
    check("post_rst vld", 32'({if_m.pout_valid, if_l.pout_valid}), 32'h3);
    check("post_rst busy0", 32'(if_m.busy), 32'h0);
    step(0,0,1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
